// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM decoder and the PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_HIGH    = 2'd1,
        ST_LOW     = 2'd2
    } pwm_state_e;

    // Nominal frame length of the generator (20 ms at 50 MHz).
    localparam int unsigned PWM_PERIOD_CYCLES = 1000000;
    // Accepted high-width window (0.5 ms .. 2.5 ms at 50 MHz).
    localparam int unsigned PWM_MIN_PULSE     = 25000;
    localparam int unsigned PWM_MAX_PULSE     = 125000;
    // Loss-of-signal timeout (22 ms at 50 MHz).
    localparam int unsigned PWM_MAX_PERIOD    = 1100000;

    function automatic logic pulse_in_range(input logic [31:0] width,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (width >= lo) && (width <= hi);
    endfunction

endpackage

// File: rtl/pwm_decoder_input_filter.sv
// Two-flop synchronizer followed by a persistence filter. The filtered level
// flips only after the synchronized input has disagreed with it for
// FILTER_LEN consecutive cycles, so both polarities see the same delay.
// rise_o/fall_o are asserted in the cycle before level_o changes.
// low_ok_o reports that the synchronized input is genuinely low (the
// synchronizer has been refilled with pin samples since reset).
module pwm_input_filter
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic low_ok_o
);

    localparam logic [7:0] FCNT_LAST = 8'(FILTER_LEN - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic [7:0] fcnt_q,  fcnt_d;
    logic [1:0] prime_q, prime_d;
    logic       flip;

    // Next-state for synchronizer, persistence counter and filtered level.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        prime_d = {prime_q[0], 1'b1};
        flip    = 1'b0;
        fcnt_d  = 8'd0;
        if (sync2_q != level_q) begin
            if (fcnt_q == FCNT_LAST) begin
                flip = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
        level_d = level_q ^ flip;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            fcnt_q  <= 8'd0;
            prime_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            prime_q <= prime_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = flip & ~level_q;
    assign fall_o   = flip &  level_q;
    assign low_ok_o = prime_q[1] & ~level_q & ~sync2_q;

endmodule

// File: rtl/pwm_decoder.sv
// Servo-style PWM decoder: measures high width and rise-to-rise period of a
// filtered input and reports accepted measurements, range errors and loss of
// signal.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_ACQUIRE | no lock; wait for a clean rising edge (partial pulse dropped)
//   ST_HIGH    | input high, counting width since the last rise
//   ST_LOW     | input low, width latched, counting toward the next rise
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned MAX_PERIOD = PWM_MAX_PERIOD,
    parameter int unsigned MIN_PULSE  = PWM_MIN_PULSE,
    parameter int unsigned MAX_PULSE  = PWM_MAX_PULSE,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [31:0] duty,
    output logic [31:0] period,
    output logic        valid,
    output logic        signal_lost,
    output logic        range_err
);

    localparam logic [31:0] MAX_PER_C = 32'(MAX_PERIOD);
    localparam logic [31:0] MIN_PUL_C = 32'(MIN_PULSE);
    localparam logic [31:0] MAX_PUL_C = 32'(MAX_PULSE);

    logic level, rise, fall, low_ok;

    pwm_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .level_o  (level),
        .rise_o   (rise),
        .fall_o   (fall),
        .low_ok_o (low_ok)
    );

    pwm_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] width_q, width_d;
    logic [31:0] duty_q, duty_d;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        range_err_q, range_err_d;
    logic        lost_q, lost_d;
    logic        armed_q, armed_d;
    logic        timeout;

    // Next-state, saturating rise-to-rise counter and measurement capture.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        duty_d      = duty_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        range_err_d = 1'b0;
        lost_d      = lost_q;
        armed_d     = 1'b0;
        timeout     = (cnt_q == MAX_PER_C) && !rise && !fall;

        if (rise) begin
            cnt_d = 32'd1;
        end else if (cnt_q >= MAX_PER_C) begin
            cnt_d = MAX_PER_C;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            ST_ACQUIRE: begin
                // A rise counts only once the input has been seen low here,
                // so a pulse already in progress is never measured.
                if (rise && armed_q) begin
                    state_d = ST_HIGH;
                end else begin
                    armed_d = armed_q | low_ok;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    width_d = cnt_q;
                    state_d = ST_LOW;
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    state_d = ST_ACQUIRE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    if (pulse_in_range(width_q, MIN_PUL_C, MAX_PUL_C)) begin
                        valid_d  = 1'b1;
                        duty_d   = width_q;
                        period_d = cnt_q;
                        lost_d   = 1'b0;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    state_d = ST_ACQUIRE;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACQUIRE;
            cnt_q       <= 32'd0;
            width_q     <= 32'd0;
            duty_q      <= 32'd0;
            period_q    <= 32'd0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            lost_q      <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            duty_q      <= duty_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
            lost_q      <= lost_d;
            armed_q     <= armed_d;
        end
    end

    assign duty        = duty_q;
    assign period      = period_q;
    assign valid       = valid_q;
    assign range_err   = range_err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder with scaled-down timing parameters. A reference model
// works from the recorded pin history: a filtered edge happens when the last
// FLEN synchronized samples all disagree with the filtered level; widths and
// periods are differences of edge times.
module tb_pwm_decoder;

    localparam int MAXP  = 2000;
    localparam int MINPU = 100;
    localparam int MAXPU = 500;
    localparam int FLEN  = 4;
    localparam int HIST  = 131072;

    localparam int P_ACQ  = 0;
    localparam int P_HIGH = 1;
    localparam int P_LOW  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] duty, period;
    logic        valid, signal_lost, range_err;

    pwm_decoder #(
        .MAX_PERIOD (MAXP),
        .MIN_PULSE  (MINPU),
        .MAX_PULSE  (MAXPU),
        .FILTER_LEN (FLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .duty        (duty),
        .period      (period),
        .valid       (valid),
        .signal_lost (signal_lost),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   k = 0;
    logic p_hist [HIST];
    int   zero_upto = -1;
    logic rst_drv = 1'b1;

    int          m_phase = P_ACQ;
    logic        m_flvl = 1'b0;
    logic        m_armed = 1'b0;
    int          m_r = 0;
    int          m_width = 0;
    logic [31:0] m_duty = 32'd0;
    logic [31:0] m_period = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_rerr = 1'b0;
    logic        m_lost = 1'b1;
    logic        prev_m_lost = 1'b1;
    logic        prev_d_lost = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Synchronized sample history; samples from before reset release read as 0.
    function automatic logic pv(input int i);
        if (i < 0 || i <= zero_upto) return 1'b0;
        return p_hist[i];
    endfunction

    task automatic model_step(input logic rst_now);
        logic all_new, rise, fall;
        int   c;
        m_valid = 1'b0;
        m_rerr  = 1'b0;
        if (rst_now) begin
            m_phase   = P_ACQ;
            m_flvl    = 1'b0;
            m_armed   = 1'b0;
            m_duty    = 32'd0;
            m_period  = 32'd0;
            m_lost    = 1'b1;
            zero_upto = k - 1;
            return;
        end
        all_new = 1'b1;
        for (int j = 0; j < FLEN; j++) begin
            if (pv(k - 3 - j) == m_flvl) all_new = 1'b0;
        end
        rise = all_new && !m_flvl;
        fall = all_new && m_flvl;
        c = ((k - m_r) > MAXP) ? MAXP : (k - m_r);
        case (m_phase)
            P_ACQ: begin
                if (rise && m_armed) begin
                    m_phase = P_HIGH;
                    m_armed = 1'b0;
                end else if (!m_flvl && (k - 3) > zero_upto && pv(k - 3) == 1'b0) begin
                    m_armed = 1'b1;
                end
            end
            P_HIGH: begin
                if (fall) begin
                    m_width = c;
                    m_phase = P_LOW;
                end else if (c == MAXP) begin
                    m_lost  = 1'b1;
                    m_phase = P_ACQ;
                    m_armed = 1'b0;
                end
            end
            default: begin
                if (rise) begin
                    m_phase = P_HIGH;
                    if (m_width >= MINPU && m_width <= MAXPU) begin
                        m_valid  = 1'b1;
                        m_duty   = 32'(m_width);
                        m_period = 32'(c);
                        m_lost   = 1'b0;
                    end else begin
                        m_rerr = 1'b1;
                    end
                end else if (c == MAXP && !fall) begin
                    m_lost  = 1'b1;
                    m_phase = P_ACQ;
                    m_armed = 1'b0;
                end
            end
        endcase
        if (rise) m_r = k;
        if (all_new) m_flvl = !m_flvl;
    endtask

    // One clock: sample just after the edge, advance the model, compare, drive next values.
    task automatic tick(input logic pin_v, input logic rst_v);
        logic evt;
        @(posedge clk);
        #1;
        k++;
        model_step(rst_drv);
        evt = m_valid || valid || m_rerr || range_err ||
              (m_lost != prev_m_lost) || (signal_lost != prev_d_lost) ||
              (k <= 3) || (k % 500 == 0);
        if (evt) begin
            chk("strobes_lost", 64'({valid, range_err, signal_lost}), 64'({m_valid, m_rerr, m_lost}));
            chk("duty", 64'(duty), 64'(m_duty));
            chk("period", 64'(period), 64'(m_period));
        end
        prev_m_lost = m_lost;
        prev_d_lost = signal_lost;
        pwm_in   = pin_v;
        reset    = rst_v;
        rst_drv  = rst_v;
        p_hist[k] = pin_v;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0);
    endtask

    task automatic pulse(input int w, input int per);
        hold(1'b1, w);
        hold(1'b0, per - w);
    endtask

    initial begin
        int w, per, g;
        p_hist[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        hold(1'b0, 10);

        // Regular frames: first valid after the second rise.
        for (int i = 0; i < 6; i++) pulse(300, 1000);

        // Short glitch while low must be ignored.
        hold(1'b0, 50);
        hold(1'b1, 3);
        hold(1'b0, 947);
        for (int i = 0; i < 2; i++) pulse(300, 1000);

        // Too-short pulse, then width boundaries.
        pulse(50, 1000);
        pulse(300, 1000);
        pulse(100, 1000);
        pulse(500, 1000);
        pulse(99, 1000);
        pulse(501, 1000);
        pulse(300, 1000);

        // Period exactly at the timeout value, then one beyond it.
        pulse(300, 2000);
        pulse(300, 2000);
        pulse(300, 2001);
        for (int i = 0; i < 2; i++) pulse(300, 1000);

        // Steady low after a measurement, then recovery.
        pulse(300, 1000);
        hold(1'b0, 2500);
        for (int i = 0; i < 3; i++) pulse(300, 1000);

        // Steady high, then recovery.
        hold(1'b1, 2500);
        hold(1'b0, 500);
        for (int i = 0; i < 3; i++) pulse(300, 1000);

        // Reset in the middle of a pulse.
        hold(1'b1, 150);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        hold(1'b1, 150);
        hold(1'b0, 700);
        for (int i = 0; i < 3; i++) pulse(300, 1000);

        // Randomized frames with occasional sub-filter glitches.
        for (int i = 0; i < 30; i++) begin
            w   = int'($urandom_range(90, 510));
            per = w + int'($urandom_range(20, 1700));
            hold(1'b1, w);
            if ($urandom_range(0, 2) == 0) begin
                g = int'($urandom_range(1, 3));
                hold(1'b0, 10);
                hold(1'b1, g);
                hold(1'b0, per - w - 10 - g);
            end else begin
                hold(1'b0, per - w);
            end
        end
        for (int i = 0; i < 2; i++) pulse(300, 1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
